// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle integer ALU for the npc execute stage.
//
// Logic, compare, shift, add and sub finish in one cycle. MUL uses an
// iterative shift-add (one multiplier bit per cycle) and DIVU/REMU use an
// iterative restoring divide (one dividend bit per cycle). Valid/ready
// handshakes on both sides let the pipeline stall on the long ops.
//
// Optional feature macro: ALU_MC_FASTMUL_EN
//   defined   : MUL is a single-cycle op built on a combinational N x N product.
//   undefined : MUL takes the iterative N-cycle shift-add path.
//   Results are identical either way; only the MUL latency changes.
//
// Parameters
//   N          operand/result width in bits (power of two, >= 8)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE and no kill this cycle)
//   A, B       unsigned operands, latched at accept
//   sel        opcode
//   kill       abort any in-flight op; a request in the same cycle is dropped
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   res        result, stable while out_valid is high
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  input  logic         kill,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res
);

  localparam int unsigned SHW = $clog2(N);

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIVU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_GEU  = 4'd7;
  localparam logic [3:0] OP_LTU  = 4'd8;
  localparam logic [3:0] OP_EQ   = 4'd9;
  localparam logic [3:0] OP_NE   = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;
  localparam logic [3:0] OP_SRL  = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [SHW-1:0] cnt_q,   cnt_d;
  logic [3:0]     op_q,    op_d;
  // opa: multiplicand (shifts left) or dividend/quotient shift register
  logic [N-1:0]   opa_q,   opa_d;
  // opb: multiplier (shifts right) or divisor (static)
  logic [N-1:0]   opb_q,   opb_d;
  // acc: product accumulator or partial remainder
  logic [N-1:0]   acc_q,   acc_d;
  logic [N-1:0]   res_q,   res_d;

  logic           accept_c;
  logic           iter_c;
  logic           mul_iter_c;
  logic           last_c;
  logic [N-1:0]   alu_c;
  logic [N-1:0]   mul_acc_c;
  logic [N:0]     rem_sh_c;
  logic           div_ge_c;
  logic [N-1:0]   rem_sub_c;
  logic [N-1:0]   rem_nx_c;
  logic [N-1:0]   quo_nx_c;

  assign in_ready  = (state_q == ST_IDLE) && !kill;
  assign out_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign accept_c  = in_valid && in_ready;
  assign last_c    = (cnt_q == SHW'(N - 1));

  // Which opcodes go through the BUSY state, and whether BUSY is multiplying
`ifdef ALU_MC_FASTMUL_EN
  assign iter_c     = (sel == OP_DIVU) || (sel == OP_REMU);
  assign mul_iter_c = 1'b0;
`else
  assign iter_c     = (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
  assign mul_iter_c = (op_q == OP_MUL);
`endif

  // Single-cycle datapath, evaluated on the live inputs at accept
  always_comb begin
    alu_c = '0;
    case (sel)
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
`ifdef ALU_MC_FASTMUL_EN
      OP_MUL:  alu_c = A * B;
`endif
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_XOR:  alu_c = A ^ B;
      OP_GEU:  alu_c = {{(N-1){1'b0}}, (A >= B)};
      OP_LTU:  alu_c = {{(N-1){1'b0}}, (A < B)};
      OP_EQ:   alu_c = {{(N-1){1'b0}}, (A == B)};
      OP_NE:   alu_c = {{(N-1){1'b0}}, (A != B)};
      OP_SLL:  alu_c = A << B[SHW-1:0];
      OP_SRL:  alu_c = A >> B[SHW-1:0];
      default: alu_c = '0;
    endcase
  end

  // Shift-add step: add the current multiplicand when the multiplier LSB is set
  assign mul_acc_c = acc_q + (opb_q[0] ? opa_q : '0);

  // Restoring divide step: bring in the next dividend MSB, subtract if it fits.
  // With a zero divisor the subtract always "fits", which yields an all-ones
  // quotient and leaves the dividend as remainder, as required.
  assign rem_sh_c  = {acc_q, opa_q[N-1]};
  assign div_ge_c  = (rem_sh_c >= {1'b0, opb_q});
  assign rem_sub_c = N'(rem_sh_c - {1'b0, opb_q});
  assign rem_nx_c  = div_ge_c ? rem_sub_c : rem_sh_c[N-1:0];
  assign quo_nx_c  = {opa_q[N-2:0], div_ge_c};

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d = sel;
          if (iter_c) begin
            opa_d   = A;
            opb_d   = B;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            res_d   = alu_c;
            state_d = ST_DONE;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + SHW'(1);
        if (mul_iter_c) begin
          acc_d = mul_acc_c;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          if (last_c) begin
            res_d = mul_acc_c;
          end
        end else begin
          acc_d = rem_nx_c;
          opa_d = quo_nx_c;
          if (last_c) begin
            res_d = (op_q == OP_REMU) ? rem_nx_c : quo_nx_c;
          end
        end
        if (last_c) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flush wins over everything; the last delivered result stays visible
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule
